cpu_decode_stage: RTL and testbench

Registered, handshaked decode pipeline stage between fetch and execute. It accepts {pc, instr} from fetch over valid/ready and decodes fields, the sign/zero-extended immediate, class flags and an illegal-instruction flag. Results are presented one cycle later through a two-entry skid buffer, so in_ready is fully registered. Extension support (M, Zifencei) and XLEN 32/64 are parameters rather than compile-time defines; a synchronous flush kills in-flight instructions on redirect.

---
 rtl/cpu_decode_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_cpu_decode_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_decode_stage.sv
// cpu_decode_stage
//   Registered, handshaked decode stage between fetch and execute. An accepted
//   {pc, instr} is decoded and presented one cycle later. A two-entry skid
//   buffer (output register + skid register) keeps in_ready fully registered.
//
// Ports
//   clk, reset            stage clock, synchronous active-high reset
//   flush                 kill every held and same-cycle incoming instruction
//   in_valid/in_ready     fetch handshake (in_ready is a flop)
//   in_pc, in_instr       instruction address and raw 32-bit word
//   out_valid/out_ready   execute handshake
//   out_pc, out_instr     registered address and raw word
//   opcode..funct12       raw fields of out_instr
//   imm                   decoded immediate, XLEN wide
//   is_*                  instruction class flags
//   illegal               encoding not supported by this configuration
module cpu_decode_stage #(
  parameter int unsigned XLEN        = 32,
  parameter bit          EN_M        = 1'b0,
  parameter bit          EN_ZIFENCEI = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [11:0]     funct12,
  output logic [XLEN-1:0] imm,
  output logic            is_mem,
  output logic            is_op_imm,
  output logic            is_op,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_system,
  output logic            is_fence,
  output logic            is_mul_div,
  output logic            illegal
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            is_mem;
    logic            is_op_imm;
    logic            is_op;
    logic            is_lui;
    logic            is_auipc;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_system;
    logic            is_fence;
    logic            is_mul_div;
    logic            illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t               d;
    logic [6:0]         f7;
    logic               shift;
    logic               f7_ok;
    logic [5:0]         shamt;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;
    f7    = w[31:25];
    // funct3 001 (sll) and 101 (srl/sra) are exactly the codes with [13:12]==01
    shift = (w[13:12] == 2'b01);
    f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000) || (EN_M && (f7 == 7'b0000001));
    shamt = (XLEN == 64) ? w[25:20] : {1'b0, w[24:20]};
    imm_i = {{20{w[31]}}, w[31:20]};
    imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_u = {w[31:12], 12'b0};
    imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    d = '0;
    // 32-bit signed immediates are widened by a signed size cast (sign extension)
    case (w[6:0])
      OPC_LOAD:  begin d.is_mem = 1'b1; d.imm = XLEN'(imm_i); end
      OPC_STORE: begin d.is_mem = 1'b1; d.imm = XLEN'(imm_s); end
      OPC_OP_IMM: begin
        d.is_op_imm = 1'b1;
        d.imm       = shift ? XLEN'(shamt) : XLEN'(imm_i);
        d.illegal   = shift && (XLEN == 32) && w[25];
      end
      OPC_OP_IMM_32: begin
        d.is_op_imm = 1'b1;
        d.imm       = shift ? XLEN'(w[24:20]) : XLEN'(imm_i);
        d.illegal   = (XLEN == 32);
      end
      OPC_OP: begin
        d.is_op   = 1'b1;
        d.illegal = !f7_ok;
      end
      OPC_OP_32: begin
        d.is_op   = 1'b1;
        d.illegal = (XLEN == 32) || !f7_ok;
      end
      OPC_LUI:    begin d.is_lui    = 1'b1; d.imm = XLEN'(imm_u); end
      OPC_AUIPC:  begin d.is_auipc  = 1'b1; d.imm = XLEN'(imm_u); end
      OPC_BRANCH: begin d.is_branch = 1'b1; d.imm = XLEN'(imm_b); end
      OPC_JAL:    begin d.is_jal    = 1'b1; d.imm = XLEN'(imm_j); end
      OPC_JALR:   begin d.is_jalr   = 1'b1; d.imm = XLEN'(imm_i); end
      OPC_SYSTEM: begin d.is_system = 1'b1; d.imm = XLEN'(imm_i); end
      OPC_MISC_MEM: begin
        d.is_fence = EN_ZIFENCEI;
        d.imm      = XLEN'(imm_i);
        d.illegal  = !EN_ZIFENCEI;
      end
      default: d.illegal = 1'b1;
    endcase
    d.is_mul_div = EN_M && d.is_op && (f7 == 7'b0000001);
    return d;
  endfunction

  logic            accept;
  logic            load_out;
  logic            out_valid_next;
  logic            skid_valid;
  logic            skid_valid_next;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  dec_t            in_dec;
  dec_t            skid_dec;
  dec_t            out_dec;

  assign accept   = in_valid && in_ready;
  // output register can take a new entry when empty or being consumed now
  assign load_out = !out_valid || out_ready;
  assign in_dec   = decode(in_instr);
  assign skid_dec = decode(skid_instr);

  always_comb begin
    out_valid_next  = out_valid;
    skid_valid_next = skid_valid;
    if (load_out) begin
      // in_ready is low whenever the skid is full, so at most one source loads
      out_valid_next  = skid_valid || accept;
      skid_valid_next = 1'b0;
    end else if (accept) begin
      skid_valid_next = 1'b1;
    end
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_pc     <= '0;
      out_instr  <= '0;
      out_dec    <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      out_valid  <= out_valid_next;
      skid_valid <= skid_valid_next;
      in_ready   <= !skid_valid_next;
      if (!flush) begin
        if (load_out && skid_valid) begin
          out_pc    <= skid_pc;
          out_instr <= skid_instr;
          out_dec   <= skid_dec;
        end else if (load_out && accept) begin
          out_pc    <= in_pc;
          out_instr <= in_instr;
          out_dec   <= in_dec;
        end else if (accept) begin
          skid_pc    <= in_pc;
          skid_instr <= in_instr;
        end
      end
    end
  end

  assign opcode     = out_instr[6:0];
  assign rd         = out_instr[11:7];
  assign funct3     = out_instr[14:12];
  assign rs1        = out_instr[19:15];
  assign rs2        = out_instr[24:20];
  assign funct7     = out_instr[31:25];
  assign funct12    = out_instr[31:20];
  assign imm        = out_dec.imm;
  assign is_mem     = out_dec.is_mem;
  assign is_op_imm  = out_dec.is_op_imm;
  assign is_op      = out_dec.is_op;
  assign is_lui     = out_dec.is_lui;
  assign is_auipc   = out_dec.is_auipc;
  assign is_branch  = out_dec.is_branch;
  assign is_jal     = out_dec.is_jal;
  assign is_jalr    = out_dec.is_jalr;
  assign is_system  = out_dec.is_system;
  assign is_fence   = out_dec.is_fence;
  assign is_mul_div = out_dec.is_mul_div;
  assign illegal    = out_dec.illegal;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Testbench for cpu_decode_stage. Two instances share one stimulus stream:
// dut_a is XLEN=32 with no extensions, dut_b is XLEN=64 with M and Zifencei.
// Expected results come from a queue-based occupancy model and a field-rule
// reference decoder; a negedge monitor compares and pops.
module tb_cpu_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_out_instr, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3;
  logic [11:0] a_funct12;
  logic a_is_mem, a_is_op_imm, a_is_op, a_is_lui, a_is_auipc, a_is_branch;
  logic a_is_jal, a_is_jalr, a_is_system, a_is_fence, a_is_mul_div, a_illegal;

  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_pc, b_imm;
  logic [31:0] b_out_instr;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3;
  logic [11:0] b_funct12;
  logic b_is_mem, b_is_op_imm, b_is_op, b_is_lui, b_is_auipc, b_is_branch;
  logic b_is_jal, b_is_jalr, b_is_system, b_is_fence, b_is_mul_div, b_illegal;

  cpu_decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_ZIFENCEI(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc[31:0]), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3), .rs1(a_rs1), .rs2(a_rs2),
    .funct7(a_funct7), .funct12(a_funct12), .imm(a_imm),
    .is_mem(a_is_mem), .is_op_imm(a_is_op_imm), .is_op(a_is_op), .is_lui(a_is_lui),
    .is_auipc(a_is_auipc), .is_branch(a_is_branch), .is_jal(a_is_jal), .is_jalr(a_is_jalr),
    .is_system(a_is_system), .is_fence(a_is_fence), .is_mul_div(a_is_mul_div),
    .illegal(a_illegal)
  );

  cpu_decode_stage #(.XLEN(64), .EN_M(1'b1), .EN_ZIFENCEI(1'b1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2),
    .funct7(b_funct7), .funct12(b_funct12), .imm(b_imm),
    .is_mem(b_is_mem), .is_op_imm(b_is_op_imm), .is_op(b_is_op), .is_lui(b_is_lui),
    .is_auipc(b_is_auipc), .is_branch(b_is_branch), .is_jal(b_is_jal), .is_jalr(b_is_jalr),
    .is_system(b_is_system), .is_fence(b_is_fence), .is_mul_div(b_is_mul_div),
    .illegal(b_illegal)
  );

  logic [10:0] a_flags, b_flags;
  assign a_flags = {a_is_mem, a_is_op_imm, a_is_op, a_is_lui, a_is_auipc, a_is_branch,
                    a_is_jal, a_is_jalr, a_is_system, a_is_fence, a_is_mul_div};
  assign b_flags = {b_is_mem, b_is_op_imm, b_is_op, b_is_lui, b_is_auipc, b_is_branch,
                    b_is_jal, b_is_jalr, b_is_system, b_is_fence, b_is_mul_div};

  // ---------------- reference decoder ----------------
  // flags bit order: mem, op_imm, op, lui, auipc, branch, jal, jalr, system, fence, mul_div
  typedef struct packed {
    logic [63:0] imm;
    logic [10:0] flags;
    logic        ill;
  } ref_t;

  typedef enum int unsigned {F_NONE, F_I, F_S, F_B, F_U, F_J, F_SH, F_SHW} fmt_e;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    ref_t        ea;
    ref_t        eb;
  } item_t;

  function automatic ref_t ref_decode(input logic [31:0] w, input int xlen, input bit en_m,
                                      input bit en_zi);
    ref_t   r;
    fmt_e   fmt;
    longint sx;
    bit     is_shift;
    bit     f7_good;
    logic [6:0] f7;
    f7       = w[31:25];
    sx       = longint'($signed(w));
    is_shift = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
    f7_good  = (f7 == 7'h00) || (f7 == 7'h20) || (en_m && f7 == 7'h01);
    r   = '0;
    fmt = F_NONE;
    case (w[6:0])
      7'h03: begin r.flags[10] = 1'b1; fmt = F_I; end
      7'h23: begin r.flags[10] = 1'b1; fmt = F_S; end
      7'h13: begin
        r.flags[9] = 1'b1;
        fmt = is_shift ? F_SH : F_I;
        r.ill = is_shift && (xlen == 32) && w[25];
      end
      7'h1B: begin
        r.flags[9] = 1'b1;
        fmt = is_shift ? F_SHW : F_I;
        r.ill = (xlen != 64);
      end
      7'h33, 7'h3B: begin
        r.flags[8] = 1'b1;
        r.ill = !f7_good || (w[6:0] == 7'h3B && xlen != 64);
        r.flags[0] = en_m && (f7 == 7'h01);
      end
      7'h37: begin r.flags[7] = 1'b1; fmt = F_U; end
      7'h17: begin r.flags[6] = 1'b1; fmt = F_U; end
      7'h63: begin r.flags[5] = 1'b1; fmt = F_B; end
      7'h6F: begin r.flags[4] = 1'b1; fmt = F_J; end
      7'h67: begin r.flags[3] = 1'b1; fmt = F_I; end
      7'h73: begin r.flags[2] = 1'b1; fmt = F_I; end
      7'h0F: begin r.flags[1] = en_zi; r.ill = !en_zi; fmt = F_I; end
      default: r.ill = 1'b1;
    endcase
    case (fmt)
      F_I:   r.imm = sx >>> 20;
      F_S:   r.imm = ((sx >>> 25) << 5) | longint'(w[11:7]);
      F_B:   r.imm = ((sx >>> 31) << 12) | (longint'(w[7]) << 11) |
                     (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      F_U:   r.imm = sx & ~64'hFFF;
      F_J:   r.imm = ((sx >>> 31) << 20) | (longint'(w[19:12]) << 12) |
                     (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      F_SH:  r.imm = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
      F_SHW: r.imm = longint'(w[24:20]);
      default: r.imm = '0;
    endcase
    return r;
  endfunction

  function automatic item_t make_item(input logic [63:0] pc, input logic [31:0] w);
    item_t it;
    it.pc    = pc;
    it.instr = w;
    it.ea    = ref_decode(w, 32, 1'b0, 1'b0);
    it.eb    = ref_decode(w, 64, 1'b1, 1'b1);
    return it;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 15))
      0: w[6:0] = 7'h03;  1: w[6:0] = 7'h23;  2: w[6:0] = 7'h13;  3: w[6:0] = 7'h1B;
      4: w[6:0] = 7'h33;  5: w[6:0] = 7'h3B;  6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;
      8: w[6:0] = 7'h63;  9: w[6:0] = 7'h6F; 10: w[6:0] = 7'h67; 11: w[6:0] = 7'h73;
      12: w[6:0] = 7'h0F;
      default: ;
    endcase
    if (w[6:0] == 7'h33 || w[6:0] == 7'h3B) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ((w[6:0] == 7'h13 || w[6:0] == 7'h1B) && $urandom_range(0, 1) == 1) begin
      w[13:12] = 2'b01;
      if ($urandom_range(0, 1) == 1) w[31:26] = 6'h00;
    end
    return w;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int    tests = 0;
  int    fails = 0;
  item_t q[$];
  item_t e;
  item_t dropped;
  bit    started = 1'b0;
  bit    zero_data = 1'b0;
  bit    exp_v, exp_r, acc, pres;
  int    req_cnt = 0;
  int    seen_cnt = 0;
  int    stream_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      exp_v = (q.size() != 0);
      exp_r = (q.size() < 2);
      chk("handshake_a", 64'({a_out_valid, a_in_ready}), 64'({exp_v, exp_r}));
      chk("handshake_b", 64'({b_out_valid, b_in_ready}), 64'({exp_v, exp_r}));
      if (exp_v) begin
        e = q[0];
        chk("pc_a",     64'(a_out_pc), 64'(e.pc[31:0]));
        chk("word_a",   64'(a_out_instr), 64'(e.instr));
        chk("fields_a", 64'({a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}), 64'(e.instr));
        chk("funct12_a", 64'(a_funct12), 64'(e.instr[31:20]));
        chk("imm_a",    64'(a_imm), 64'(e.ea.imm[31:0]));
        chk("class_a",  64'({a_flags, a_illegal}), 64'({e.ea.flags, e.ea.ill}));
        chk("pc_b",     b_out_pc, e.pc);
        chk("fields_b", 64'({b_funct7, b_rs2, b_rs1, b_funct3, b_rd, b_opcode}), 64'(e.instr));
        chk("word_b",   64'(b_out_instr), 64'(e.instr));
        chk("funct12_b", 64'(b_funct12), 64'(e.instr[31:20]));
        chk("imm_b",    b_imm, e.eb.imm);
        chk("class_b",  64'({b_flags, b_illegal}), 64'({e.eb.flags, e.eb.ill}));
      end else if (zero_data) begin
        chk("rst_data_a", 64'({a_out_pc, a_out_instr}), 64'(0));
        chk("rst_dec_a",  64'({a_imm, a_flags, a_illegal}), 64'(0));
        chk("rst_pc_b",   b_out_pc, 64'(0));
        chk("rst_imm_b",  b_imm, 64'(0));
        chk("rst_dec_b",  64'({b_out_instr, b_flags, b_illegal}), 64'(0));
      end
    end
    if (req_cnt != seen_cnt) begin
      chk("stream_accepts", 64'(stream_n), 64'(6));
      seen_cnt = req_cnt;
    end
    // advance the model with the inputs the next rising edge will see
    if (reset) begin
      q.delete();
      started   = 1'b1;
      zero_data = 1'b1;
    end else if (started) begin
      acc  = in_valid && (q.size() < 2);
      pres = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pres) dropped = q.pop_front();
        if (acc) begin
          q.push_back(make_item(in_pc, in_instr));
          zero_data = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit fl, input bit v, input bit ordy,
                       input logic [31:0] w, input logic [63:0] pc, output bit took);
    @(posedge clk);
    #1;
    reset     = rst;
    flush     = fl;
    in_valid  = v;
    out_ready = ordy;
    in_instr  = w;
    in_pc     = pc;
    took      = v && a_in_ready && !fl && !rst;
  endtask

  bit          took, r_rst, r_fl, r_v, r_rdy;
  logic [31:0] cur_w;
  logic [63:0] cur_pc;
  logic [31:0] stream_w [6];
  int          c;

  initial begin
    stream_w[0] = 32'hFFF10093; stream_w[1] = 32'h022081B3; stream_w[2] = 32'h03F09093;
    stream_w[3] = 32'h00000000; stream_w[4] = 32'h00A12023; stream_w[5] = 32'h004000EF;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, took);

    // single instructions with the sink always ready
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFF10093, 64'h100, took);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h022081B3, 64'h104, took);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h03F09093, 64'h108, took);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 64'h10C, took);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000100F, 64'h110, took);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, took);

    // six-instruction stream with a three-cycle sink stall
    stream_n = 0;
    c = 0;
    while (stream_n < 6 && c < 40) begin
      drive(1'b0, 1'b0, 1'b1, !(c >= 2 && c < 5), stream_w[stream_n],
            64'h200 + 64'(4 * stream_n), took);
      if (took) stream_n++;
      c++;
    end
    req_cnt++;
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, took);

    // fill output and skid, then flush with a third instruction pending
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h00500093, 64'h300, took);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h00600113, 64'h304, took);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h00700193, 64'h308, took);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, took);
    // flush while an accept would otherwise happen
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h00800213, 64'h30C, took);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, took);

    // reset in the middle of a stalled stream
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h123452B7, 64'h400, took);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hFE000EE3, 64'h404, took);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h00C00313, 64'h408, took);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000006F, 64'h40C, took);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, took);

    // randomized traffic
    cur_w  = gen_instr();
    cur_pc = {$urandom(), $urandom()};
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 249) == 0);
      r_fl  = ($urandom_range(0, 39) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      drive(r_rst, r_fl, r_v, r_rdy, cur_w, cur_pc, took);
      if (took || r_fl || r_rst) begin
        cur_w  = gen_instr();
        cur_pc = {$urandom(), $urandom()};
      end
    end

    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, took);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
